// File: rtl/hamming_dec_engine.sv
// SECDED decoder engine: reads N_MSG 16-bit codewords from data memory, corrects single errors,
// flags double errors and writes each 11-bit message plus a 2-bit status back to memory.
module hamming_dec_engine #(
    parameter int unsigned SRC_BASE = 30,
    parameter int unsigned DST_BASE = 0,
    parameter int unsigned N_MSG    = 15
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       start,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic [7:0] mem_wr_data,
    output logic       mem_wr_en,
    output logic       busy,
    output logic       done,
    output logic [7:0] single_cnt,
    output logic [7:0] double_cnt
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StRdLo   = 3'd1;
    localparam logic [2:0] StRdHi   = 3'd2;
    localparam logic [2:0] StDecode = 3'd3;
    localparam logic [2:0] StWrLo   = 3'd4;
    localparam logic [2:0] StWrHi   = 3'd5;
    localparam logic [2:0] StDone   = 3'd6;

    localparam logic [7:0] SrcBase = 8'(SRC_BASE);
    localparam logic [7:0] DstBase = 8'(DST_BASE);
    localparam logic [6:0] LastIdx = 7'(N_MSG - 1);

    logic [2:0]  state_q, state_d;
    logic [6:0]  idx_q, idx_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic [11:1] data_q, data_d;
    logic [1:0]  flag_q, flag_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  single_q, single_d;
    logic [7:0]  double_q, double_d;

    logic [15:0] word;
    logic [15:0] fixed;
    logic [3:0]  syn;
    logic        par;
    logic [11:1] dec_data;
    logic        is_single;
    logic        is_double;
    logic [7:0]  idx2;

    // Syndrome, overall parity and corrected data for the latched codeword.
    always_comb begin
        word = {hi_q, lo_q};
        syn  = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (word[k]) begin
                syn = syn ^ 4'(k);
            end
        end
        par   = ^word;
        fixed = word;
        if (par && (syn != 4'd0)) begin
            fixed[syn] = ~word[syn];
        end
        dec_data  = {fixed[15:9], fixed[7], fixed[6], fixed[5], fixed[3]};
        is_single = par;
        is_double = !par && (syn != 4'd0);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        data_d   = data_q;
        flag_d   = flag_q;
        single_d = single_q;
        double_d = double_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StRdLo;
                    idx_d    = 7'd0;
                    single_d = 8'd0;
                    double_d = 8'd0;
                end
            end
            StRdLo: begin
                lo_d    = mem_rd_data;
                state_d = StRdHi;
            end
            StRdHi: begin
                hi_d    = mem_rd_data;
                state_d = StDecode;
            end
            StDecode: begin
                data_d = dec_data;
                flag_d = {is_double, is_single};
                if (is_single && (single_q != 8'hFF)) begin
                    single_d = single_q + 8'd1;
                end
                if (is_double && (double_q != 8'hFF)) begin
                    double_d = double_q + 8'd1;
                end
                state_d = StWrLo;
            end
            StWrLo: begin
                state_d = StWrHi;
            end
            StWrHi: begin
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 7'd1;
                    state_d = StRdLo;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Address arithmetic wraps modulo 256, matching the 8-bit memory space.
    assign idx2 = {idx_q, 1'b0};

    always_comb begin
        mem_addr    = addr_q;
        mem_wr_data = 8'd0;
        mem_wr_en   = 1'b0;
        case (state_q)
            StRdLo: begin
                mem_addr = SrcBase + idx2;
            end
            StRdHi: begin
                mem_addr = SrcBase + idx2 + 8'd1;
            end
            StWrLo: begin
                mem_addr    = DstBase + idx2;
                mem_wr_data = data_q[8:1];
                mem_wr_en   = 1'b1;
            end
            StWrHi: begin
                mem_addr    = DstBase + idx2 + 8'd1;
                mem_wr_data = {flag_q, 3'b000, data_q[11:9]};
                mem_wr_en   = 1'b1;
            end
            default: begin
                mem_addr = addr_q;
            end
        endcase
        addr_d = mem_addr;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= StIdle;
            idx_q    <= 7'd0;
            lo_q     <= 8'd0;
            hi_q     <= 8'd0;
            data_q   <= 11'd0;
            flag_q   <= 2'b00;
            addr_q   <= 8'd0;
            single_q <= 8'd0;
            double_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            data_q   <= data_d;
            flag_q   <= flag_d;
            addr_q   <= addr_d;
            single_q <= single_d;
            double_q <= double_d;
        end
    end

    assign busy       = (state_q != StIdle) && (state_q != StDone);
    assign done       = (state_q == StDone);
    assign single_cnt = single_q;
    assign double_cnt = double_q;

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Scoreboard bench for hamming_dec_engine: expected memory writes are queued at stimulus time
// and a monitor pops and compares them whenever the engine writes.
module tb_hamming_dec_engine;

    localparam int N   = 15;
    localparam int SRC = 30;
    localparam int DST = 0;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       start;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic [7:0] mem_wr_data;
    logic       mem_wr_en;
    logic       busy;
    logic       done;
    logic [7:0] single_cnt;
    logic [7:0] double_cnt;

    logic [7:0] mem [256];

    typedef struct packed {
        logic [7:0] m;
        logic [7:0] a;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Hand-encoded codewords and their decoded lo/hi output bytes.
    logic [15:0] cw [0:14] = '{16'h0000, 16'hFFFF, 16'h0040, 16'hFFFE, 16'h0003,
                               16'h000F, 16'h100F, 16'h0027, 16'h7FFF, 16'hF9FF,
                               16'h0001, 16'h0100, 16'h2112, 16'h2192, 16'h0113};
    logic [7:0] exp_lo [0:14] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h01, 8'h02,
                                  8'hFF, 8'hCF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] exp_hi [0:14] = '{8'h00, 8'h07, 8'h40, 8'h47, 8'h80, 8'h00, 8'h40, 8'h80,
                                  8'h47, 8'h87, 8'h40, 8'h40, 8'h01, 8'h41, 8'h80};

    hamming_dec_engine #(
        .SRC_BASE(SRC),
        .DST_BASE(DST),
        .N_MSG   (N)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .start      (start),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .mem_wr_data(mem_wr_data),
        .mem_wr_en  (mem_wr_en),
        .busy       (busy),
        .done       (done),
        .single_cnt (single_cnt),
        .double_cnt (double_cnt)
    );

    always #5 CLK = ~CLK;

    assign mem_rd_data = mem[mem_addr];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_and_expect();
        for (int i = 0; i < N; i++) begin
            mem[SRC + 2 * i]     = cw[i][7:0];
            mem[SRC + 2 * i + 1] = cw[i][15:8];
            mem[DST + 2 * i]     = 8'hAA;
            mem[DST + 2 * i + 1] = 8'hAA;
            sb.push_back({8'(i), 8'(DST + 2 * i), exp_lo[i]});
            sb.push_back({8'(i), 8'(DST + 2 * i + 1), exp_hi[i]});
        end
    endtask

    // Clock 1 is the edge that samples start; done_clk is the first clock after which done is high.
    task automatic run(input int busy_start_at, input int reset_at, output int done_clk);
        int clk_n;
        done_clk = 0;
        clk_n    = 0;
        @(negedge CLK);
        start = 1'b1;
        while (clk_n < 200 && done_clk == 0 && !(reset_at > 0 && clk_n == reset_at)) begin
            @(posedge CLK);
            #1;
            clk_n++;
            start = (clk_n == busy_start_at);
            if (clk_n == 1) chk("busy_after_start", int'(busy), 1);
            if (reset_at > 0 && clk_n == reset_at - 1) Reset = 1'b1;
            if (done) done_clk = clk_n;
        end
    endtask

    initial begin
        int dclk;
        Reset = 1'b1;
        start = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;

        fork
            forever begin
                @(posedge CLK);
                if (mem_wr_en) mem[mem_addr] = mem_wr_data;
            end
            forever begin
                exp_t e;
                @(negedge CLK);
                if (mem_wr_en) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr=%0h data=%0h with nothing expected",
                                 mem_addr, mem_wr_data);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("msg%0d_addr", e.m), int'(mem_addr), int'(e.a));
                        chk($sformatf("msg%0d_data", e.m), int'(mem_wr_data), int'(e.d));
                    end
                end
            end
        join_none

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wr_en", int'(mem_wr_en), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_wr_data", int'(mem_wr_data), 0);
        chk("rst_single", int'(single_cnt), 0);
        chk("rst_double", int'(double_cnt), 0);
        Reset = 1'b0;

        // Run 1: full run with a start pulse injected while busy.
        load_and_expect();
        run(20, 0, dclk);
        chk("run1_done_clock", dclk, 76);
        chk("run1_busy", int'(busy), 0);
        chk("run1_single", int'(single_cnt), 7);
        chk("run1_double", int'(double_cnt), 4);
        chk("run1_sb_empty", sb.size(), 0);
        chk("run1_mem0", int'(mem[0]), 8'h00);
        chk("run1_mem3", int'(mem[3]), 8'h07);
        chk("run1_mem7", int'(mem[7]), 8'h47);
        repeat (5) @(posedge CLK);
        #1;
        chk("run1_done_held", int'(done), 1);
        chk("run1_single_held", int'(single_cnt), 7);

        // Run 2: reset lands at clock 40, mid-run.
        load_and_expect();
        run(0, 40, dclk);
        sb.delete();
        chk("rst40_busy", int'(busy), 0);
        chk("rst40_done", int'(done), 0);
        chk("rst40_wr_en", int'(mem_wr_en), 0);
        chk("rst40_addr", int'(mem_addr), 0);
        chk("rst40_single", int'(single_cnt), 0);
        chk("rst40_double", int'(double_cnt), 0);
        Reset = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst40_idle_busy", int'(busy), 0);

        // Run 3: clean full run after the mid-run reset.
        load_and_expect();
        run(0, 0, dclk);
        chk("run3_done_clock", dclk, 76);
        chk("run3_single", int'(single_cnt), 7);
        chk("run3_double", int'(double_cnt), 4);
        chk("run3_sb_empty", sb.size(), 0);
        chk("run3_mem18", int'(mem[18]), 8'hCF);
        chk("run3_mem19", int'(mem[19]), 8'h87);
        chk("run3_mem29", int'(mem[29]), 8'h80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
